// File: rtl/frame_rx_fifo.sv
// frame_rx_fifo: oversampled serial frame receiver with show-ahead byte FIFO.
// Frame: start(1) | LEN (LEN_W, MSB first) | LEN data bytes (MSB first) |
//        CRC-8 (MSB first) | stop(0). Each bit is a majority vote over one
//        bit period of B = max(baudrate, 3) clocks.
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   rx               asynchronous serial line (idles 0)
//   baudrate         clocks per bit
//   rd               pop FIFO head (ignored while dr = 0)
//   dataout, dr      FIFO head (0 when empty), FIFO not empty
//   frame_done       one-cycle pulse after the stop bit
//   frame_len        LEN field of the last frame
//   nf/over/crcerr/fe  noise, dropped byte, CRC mismatch, framing error
module frame_rx_fifo #(
    parameter int unsigned BAUD_W     = 8,
    parameter int unsigned LEN_W      = 4,
    parameter int unsigned MAX_BYTES  = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [7:0]  CRC_POLY   = 8'h07,
    parameter logic [7:0]  CRC_INIT   = 8'h00,
    parameter int unsigned NOISE_TH   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    input  logic [BAUD_W-1:0] baudrate,
    input  logic              rd,
    output logic [7:0]        dataout,
    output logic              dr,
    output logic              frame_done,
    output logic [LEN_W-1:0]  frame_len,
    output logic              nf,
    output logic              over,
    output logic              crcerr,
    output logic              fe
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [BAUD_W:0] NTH = (BAUD_W+1)'(NOISE_TH);
    localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_LEN, S_DATA, S_CRC, S_STOP} state_t;
    state_t state, state_d;

    logic rx_m, rxs;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_m <= 1'b0;
            rxs  <= 1'b0;
        end else begin
            rx_m <= rx;
            rxs  <= rx_m;
        end
    end

    // Bit-period sampling and majority vote
    logic [BAUD_W-1:0] beff, cnt, ones;
    logic [BAUD_W:0]   ones_tot, zeros_tot, minority;
    logic              bit_end, bitv, noisy;

    assign beff      = (baudrate < BAUD_W'(3)) ? BAUD_W'(3) : baudrate;
    assign ones_tot  = {1'b0, ones} + {{BAUD_W{1'b0}}, rxs};
    assign zeros_tot = {1'b0, beff} - ones_tot;
    assign minority  = (ones_tot < zeros_tot) ? ones_tot : zeros_tot;
    assign bit_end   = (state != S_IDLE) && (cnt == beff - BAUD_W'(1));
    assign bitv      = {ones_tot, 1'b0} > {2'b00, beff};
    assign noisy     = minority > NTH;

    // The IDLE cycle that first sees rxs=1 is sample 0 of the start bit,
    // so the counter enters START already at sample 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            ones <= '0;
        end else if (state == S_IDLE) begin
            cnt  <= rxs ? BAUD_W'(1) : '0;
            ones <= rxs ? BAUD_W'(1) : '0;
        end else if (bit_end) begin
            cnt  <= '0;
            ones <= '0;
        end else begin
            cnt  <= cnt + BAUD_W'(1);
            ones <= ones_tot[BAUD_W-1:0];
        end
    end

    // Field datapath
    logic [7:0]       fcnt;
    logic [6:0]       shreg;
    logic [7:0]       byte_nx, crc, crc_nx;
    logic [LEN_W-1:0] len_q, len_nx, byte_idx;
    logic             byte_end, field_done, idx_ok, push, pop, full;

    assign byte_nx  = {shreg, bitv};
    assign len_nx   = (len_q << 1) | LEN_W'(bitv);
    assign crc_nx   = {crc[6:0], 1'b0} ^ ((crc[7] ^ bitv) ? CRC_POLY : 8'h00);
    assign byte_end = bit_end && (state == S_DATA) && (fcnt == 8'd7);
    assign idx_ok   = 32'(byte_idx) < MAX_BYTES;

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (rxs) state_d = S_START;
            S_START: if (bit_end) state_d = bitv ? S_LEN : S_IDLE;
            S_LEN:   if (bit_end && fcnt == 8'(LEN_W - 1))
                         state_d = (len_nx == '0) ? S_CRC : S_DATA;
            S_DATA:  if (byte_end && byte_idx == len_q - LEN_W'(1)) state_d = S_CRC;
            S_CRC:   if (bit_end && fcnt == 8'd7) state_d = S_STOP;
            S_STOP:  if (bit_end) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign field_done = (state_d != state) || byte_end;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fcnt       <= '0;
            shreg      <= '0;
            len_q      <= '0;
            byte_idx   <= '0;
            crc        <= '0;
            nf         <= 1'b0;
            over       <= 1'b0;
            crcerr     <= 1'b0;
            fe         <= 1'b0;
            frame_done <= 1'b0;
            frame_len  <= '0;
        end else begin
            frame_done <= 1'b0;
            if (bit_end) begin
                fcnt  <= field_done ? '0 : fcnt + 8'd1;
                shreg <= byte_nx[6:0];
                if (state != S_START && noisy) nf <= 1'b1;
                case (state)
                    S_START: if (bitv) begin
                        nf       <= 1'b0;
                        over     <= 1'b0;
                        crcerr   <= 1'b0;
                        fe       <= 1'b0;
                        crc      <= CRC_INIT;
                        byte_idx <= '0;
                    end
                    S_LEN:  len_q <= len_nx;
                    S_DATA: begin
                        crc <= crc_nx;
                        if (byte_end) begin
                            byte_idx <= byte_idx + LEN_W'(1);
                            if (!push) over <= 1'b1;
                        end
                    end
                    S_CRC:  if (fcnt == 8'd7) crcerr <= (byte_nx != crc);
                    S_STOP: begin
                        if (bitv) fe <= 1'b1;
                        frame_done <= 1'b1;
                        frame_len  <= len_q;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Show-ahead FIFO
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;

    assign dr      = (count != '0);
    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign pop     = rd && dr;
    // A full FIFO still accepts a byte when the head is popped in the same cycle.
    assign push    = byte_end && idx_ok && (!full || pop);
    assign dataout = dr ? mem[rptr] : 8'h00;

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= byte_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: ;
            endcase
        end
    end
endmodule
